// File: rtl/len5_credit_pkg.sv
// Shared constants and width helper for the credit-based link transmitter.
package len5_credit_pkg;

  localparam int CREDIT_DEFAULT = 4;

  // Counter must represent 0..credits inclusive.
  function automatic int cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/credit_tx_counter.sv
// Saturating up/down credit counter; clr reloads MAX, ovf_o flags an increment at MAX.
module credit_counter
  import len5_credit_pkg::*;
#(
  parameter  int MAX = CREDIT_DEFAULT,
  localparam int W   = cnt_width(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         nonzero_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = MaxVal;
    end else if (inc_i && !dec_i) begin
      if (count_q != MaxVal) count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= MaxVal;
    else          count_q <= count_d;
  end

  assign count_o   = count_q;
  assign nonzero_o = (count_q != '0);
  assign ovf_o     = !clr_i && inc_i && !dec_i && (count_q == MaxVal);

endmodule

// File: rtl/credit_tx.sv
// Credit-based link transmitter: upstream valid/ready in, registered one-cycle valid pulses out.
// Ready comes only from the local credit register, so no combinational path crosses the link.
module credit_tx
  import len5_credit_pkg::*;
#(
  parameter  type  DATA_T  = logic,
  parameter  int   CREDITS = CREDIT_DEFAULT,
  parameter  logic SKIP    = 1'b0,
  localparam int   CNT_W   = cnt_width(CREDITS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  DATA_T            data_i,
  output logic             valid_o,
  output DATA_T            data_o,
  input  logic             credit_i,
  output logic [CNT_W-1:0] credits_o,
  output logic             credit_err_o
);

  if (SKIP) begin : g_skip
    assign valid_o      = valid_i;
    assign data_o       = data_i;
    assign ready_o      = 1'b1;
    assign credits_o    = CNT_W'(CREDITS);
    assign credit_err_o = 1'b0;
  end else begin : g_credit
    logic  accept;
    logic  nonzero, ovf;
    logic  valid_d, valid_q;
    DATA_T data_d, data_q;
    logic  err_d, err_q;

    // Flush beats both accept and credit return; credits during flush are dropped silently.
    assign accept = valid_i && nonzero && !flush_i;

    credit_counter #(
      .MAX (CREDITS)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (flush_i),
      .inc_i     (credit_i),
      .dec_i     (accept),
      .count_o   (credits_o),
      .nonzero_o (nonzero),
      .ovf_o     (ovf)
    );

    always_comb begin
      valid_d = accept;
      data_d  = accept ? data_i : data_q;
      err_d   = err_q | ovf;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        err_q   <= err_d;
      end
    end

    assign ready_o      = nonzero;
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign credit_err_o = err_q;

    a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      credits_o <= CNT_W'(CREDITS));
    a_no_accept_empty : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(accept && credits_o == '0));
    a_known : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !$isunknown(credit_i) && !$isunknown(valid_o));
    a_overflow : assert property (@(posedge clk_i) disable iff (!rst_n_i) !ovf)
      else $warning("credit_tx: credit returned while counter already full");
  end

endmodule

// File: tb/tb_credit_tx.sv
// Directed table-driven bench for credit_tx (CREDITS=4) plus reset and bypass sequences.
module tb_credit_tx;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       flush_i, valid_i, credit_i;
  logic [7:0] data_i;

  logic       ready_o, valid_o, credit_err_o;
  logic [7:0] data_o;
  logic [2:0] credits_o;

  logic       s_ready_o, s_valid_o, s_credit_err_o;
  logic [7:0] s_data_o;
  logic [2:0] s_credits_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  credit_tx #(.DATA_T(logic [7:0]), .CREDITS(4), .SKIP(1'b0)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .data_o(data_o), .credit_i(credit_i),
    .credits_o(credits_o), .credit_err_o(credit_err_o)
  );

  credit_tx #(.DATA_T(logic [7:0]), .CREDITS(4), .SKIP(1'b1)) u_skip (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(s_ready_o), .data_i(data_i),
    .valid_o(s_valid_o), .data_o(s_data_o), .credit_i(credit_i),
    .credits_o(s_credits_o), .credit_err_o(s_credit_err_o)
  );

  typedef struct packed {
    logic       vld;
    logic [7:0] dat;
    logic       crd;
    logic       fl;
    logic       e_vld;
    logic [7:0] e_dat;
    logic [2:0] e_cr;
    logic       e_rdy;
    logic       e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic vld, input logic [7:0] dat, input logic crd, input logic fl,
                     input logic e_vld, input logic [7:0] e_dat, input logic [2:0] e_cr,
                     input logic e_rdy, input logic e_err);
    vec_t v;
    v = '{vld, dat, crd, fl, e_vld, e_dat, e_cr, e_rdy, e_err};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_vld, input logic [7:0] e_dat,
                         input logic [2:0] e_cr, input logic e_rdy, input logic e_err);
    chk({tag, ".valid_o"},      {31'd0, valid_o},      {31'd0, e_vld});
    chk({tag, ".data_o"},       {24'd0, data_o},       {24'd0, e_dat});
    chk({tag, ".credits_o"},    {29'd0, credits_o},    {29'd0, e_cr});
    chk({tag, ".ready_o"},      {31'd0, ready_o},      {31'd0, e_rdy});
    chk({tag, ".credit_err_o"}, {31'd0, credit_err_o}, {31'd0, e_err});
  endtask

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; credit_i = 1'b0; data_i = 8'h00;

    //   vld dat    crd fl | e_vld e_dat  cr rdy err
    // drain four credits with valid held high, fifth item held back
    add(1, 8'h01, 0, 0,  1, 8'h01, 3'd3, 1, 0);
    add(1, 8'h02, 0, 0,  1, 8'h02, 3'd2, 1, 0);
    add(1, 8'h03, 0, 0,  1, 8'h03, 3'd1, 1, 0);
    add(1, 8'h04, 0, 0,  1, 8'h04, 3'd0, 0, 0);
    add(1, 8'h05, 0, 0,  0, 8'h04, 3'd0, 0, 0);
    // one credit back from empty, then 0x5 goes through
    add(1, 8'h05, 1, 0,  0, 8'h04, 3'd1, 1, 0);
    add(1, 8'h05, 0, 0,  1, 8'h05, 3'd0, 0, 0);
    // refill to 2, then stream with credit every cycle
    add(0, 8'h00, 1, 0,  0, 8'h05, 3'd1, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h05, 3'd2, 1, 0);
    add(1, 8'h10, 1, 0,  1, 8'h10, 3'd2, 1, 0);
    add(1, 8'h11, 1, 0,  1, 8'h11, 3'd2, 1, 0);
    add(1, 8'h12, 1, 0,  1, 8'h12, 3'd2, 1, 0);
    // refill to full, one extra credit overflows, err survives flush
    add(0, 8'h00, 1, 0,  0, 8'h12, 3'd3, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h12, 3'd4, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h12, 3'd4, 1, 1);
    add(0, 8'h00, 0, 1,  0, 8'h12, 3'd4, 1, 1);
    // down to 1, then flush with valid and credit together
    add(1, 8'h20, 0, 0,  1, 8'h20, 3'd3, 1, 1);
    add(1, 8'h21, 0, 0,  1, 8'h21, 3'd2, 1, 1);
    add(1, 8'h22, 0, 0,  1, 8'h22, 3'd1, 1, 1);
    add(1, 8'h23, 1, 1,  0, 8'h22, 3'd4, 1, 1);
    add(0, 8'h00, 0, 0,  0, 8'h22, 3'd4, 1, 1);

    repeat (2) @(posedge clk_i);
    #1;
    chk_all("reset", 1'b0, 8'h00, 3'd4, 1'b1, 1'b0);
    rst_n_i = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      valid_i  = vq[i].vld;
      data_i   = vq[i].dat;
      credit_i = vq[i].crd;
      flush_i  = vq[i].fl;
      @(posedge clk_i);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].e_vld, vq[i].e_dat, vq[i].e_cr,
              vq[i].e_rdy, vq[i].e_err);
    end

    // asynchronous reset right after an accept drops the in-flight pulse
    valid_i = 1'b1; data_i = 8'h33; credit_i = 1'b0; flush_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk_all("pre_rst", 1'b1, 8'h33, 3'd3, 1'b1, 1'b1);
    rst_n_i = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 8'h00, 3'd4, 1'b1, 1'b0);
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // bypass instance follows inputs combinationally
    valid_i = 1'b1; data_i = 8'h5A;
    #1;
    chk("skip.valid_o", {31'd0, s_valid_o}, 32'd1);
    chk("skip.data_o", {24'd0, s_data_o}, 32'h5A);
    chk("skip.ready_o", {31'd0, s_ready_o}, 32'd1);
    valid_i = 1'b0; data_i = 8'hA5; credit_i = 1'b1;
    #1;
    chk("skip.valid_o_low", {31'd0, s_valid_o}, 32'd0);
    chk("skip.data_o_2", {24'd0, s_data_o}, 32'hA5);
    chk("skip.ready_o_2", {31'd0, s_ready_o}, 32'd1);
    chk("skip.credit_err_o", {31'd0, s_credit_err_o}, 32'd0);
    credit_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
